full_fn_csr_seq: RTL and testbench

Parametrised Avalon-MM control/status block with an integrated stream sequencer for the cosine CORDIC full-function datapath. It sits between the mSGDMA read stream and the accelerator input, and snoops the accelerator result stream. Software programs an element count and starts a job; the block gates exactly that many input beats through, counts returned results, and reports busy/done/abort status, progress and an optional interrupt.

---
 rtl/full_fn_csr_seq.sv | 257 +++++++++++++++++++++++++
 tb/tb_full_fn_csr_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/full_fn_csr_seq.sv
// full_fn_csr_seq: Avalon-MM CSR block with an integrated stream sequencer for the
// cosine CORDIC full-function datapath. Gates exactly COUNT input beats from the
// mSGDMA stream into the accelerator and counts the snooped result beats.
// Optional feature macro: FULL_FN_IRQ_EN (irq_pending/irq_en flops and level irq).
module full_fn_csr_seq #(
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned ADDR_W = 3
) (
    input  logic              clk,
    input  logic              aclr,
    input  logic              read,
    input  logic              write,
    input  logic [ADDR_W-1:0] address,
    input  logic [31:0]       writedata,
    output logic [31:0]       readdata,
    input  logic              s_valid,
    output logic              s_ready,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              res_valid,
    input  logic              res_ready,
    output logic              irq
);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StDrain = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    localparam logic [ADDR_W-1:0] AddrCtrl     = ADDR_W'(0);
    localparam logic [ADDR_W-1:0] AddrCount    = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] AddrStatus   = ADDR_W'(2);
    localparam logic [ADDR_W-1:0] AddrProgress = ADDR_W'(3);
    localparam logic [ADDR_W-1:0] AddrIssued   = ADDR_W'(4);
    localparam logic [ADDR_W-1:0] AddrVersion  = ADDR_W'(5);

    localparam logic [31:0]      Version = 32'h0002_0000;
    localparam logic [CNT_W-1:0] CntOne  = CNT_W'(1);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] progress_q, progress_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic [31:0]      readdata_q, readdata_d;

    logic        wr_en;
    logic        ctrl_wr;
    logic        soft_rst;
    logic        start_p;
    logic        abort_p;
    logic        busy;
    logic        gate_en;
    logic        s_beat;
    logic        r_beat;
    logic        start_ok;
    logic        enter_done;
    logic        status_w1c;
    logic        irq_pend_rd;
    logic        irq_en_rd;
    logic [31:0] rd_word;

    // Bus strobes: read has priority, so a colliding write is simply dropped.
    always_comb begin
        wr_en      = write & ~read;
        ctrl_wr    = wr_en && (address == AddrCtrl);
        soft_rst   = ctrl_wr & writedata[0];
        start_p    = ctrl_wr & writedata[1];
        abort_p    = ctrl_wr & writedata[2];
        status_w1c = wr_en && (address == AddrStatus) && writedata[3];
    end

    // Stream gate: open only while running and not all elements have been issued.
    always_comb begin
        busy    = (state_q == StRun) || (state_q == StDrain);
        gate_en = (state_q == StRun) && (issued_q != count_q);
        m_valid = s_valid & gate_en;
        s_ready = m_ready & gate_en;
        s_beat  = s_valid & s_ready;
        // Extra results beyond COUNT are never counted, so progress cannot wrap.
        r_beat  = res_valid & res_ready & busy & (progress_q != count_q);
    end

    // Read mux, sampling register state before any same-cycle update.
    always_comb begin
        rd_word = '0;
        unique case (address)
            AddrCtrl:     rd_word[3] = irq_en_rd;
            AddrCount:    rd_word[CNT_W-1:0] = count_q;
            AddrStatus:   rd_word[3:0] = {irq_pend_rd, aborted_q, done_q, busy};
            AddrProgress: rd_word[CNT_W-1:0] = progress_q;
            AddrIssued:   rd_word[CNT_W-1:0] = issued_q;
            AddrVersion:  rd_word = Version;
            default:      rd_word = '0;
        endcase
    end

    // Next-state for the FSM, counters, COUNT and read data.
    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        issued_d   = issued_q;
        progress_d = progress_q;
        done_d     = done_q;
        aborted_d  = aborted_q;
        readdata_d = readdata_q;
        start_ok   = 1'b0;
        enter_done = 1'b0;

        if (read) begin
            readdata_d = rd_word;
        end

        if (wr_en && (address == AddrCount) && !busy) begin
            count_d = writedata[CNT_W-1:0];
        end

        if (s_beat) begin
            issued_d = issued_q + CntOne;
        end
        if (r_beat) begin
            progress_d = progress_q + CntOne;
        end

        case (state_q)
            StRun: begin
                if (progress_d == count_q) begin
                    enter_done = 1'b1;
                end else if (issued_d == count_q) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (progress_d == count_q) begin
                    enter_done = 1'b1;
                end
            end
            default: begin
                if (start_p) begin
                    start_ok   = 1'b1;
                    issued_d   = '0;
                    progress_d = '0;
                    done_d     = 1'b0;
                    aborted_d  = 1'b0;
                    // A zero-length job completes without ever opening the gate.
                    if (count_q == '0) begin
                        enter_done = 1'b1;
                    end else begin
                        state_d = StRun;
                    end
                end
            end
        endcase

        if (enter_done) begin
            state_d = StDone;
            done_d  = 1'b1;
        end

        // Abort beats start and a coinciding final result; counters freeze for readback.
        if (abort_p) begin
            enter_done = 1'b0;
            start_ok   = 1'b0;
            state_d    = StIdle;
            aborted_d  = 1'b1;
            done_d     = 1'b0;
            issued_d   = issued_q;
            progress_d = progress_q;
        end

        if (soft_rst) begin
            enter_done = 1'b0;
            start_ok   = 1'b0;
            state_d    = StIdle;
            count_d    = '0;
            issued_d   = '0;
            progress_d = '0;
            done_d     = 1'b0;
            aborted_d  = 1'b0;
            readdata_d = '0;
        end
    end

    // Core state registers with asynchronous reset.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            state_q    <= StIdle;
            count_q    <= '0;
            issued_q   <= '0;
            progress_q <= '0;
            done_q     <= 1'b0;
            aborted_q  <= 1'b0;
            readdata_q <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            issued_q   <= issued_d;
            progress_q <= progress_d;
            done_q     <= done_d;
            aborted_q  <= aborted_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;

`ifdef FULL_FN_IRQ_EN
    logic irq_en_q, irq_en_d;
    logic irq_pend_q, irq_pend_d;

    // Interrupt enable and pending: set on DONE entry wins over a same-cycle W1C.
    always_comb begin
        irq_en_d   = irq_en_q;
        irq_pend_d = irq_pend_q;
        if (ctrl_wr) begin
            irq_en_d = writedata[3];
        end
        if (status_w1c || start_ok) begin
            irq_pend_d = 1'b0;
        end
        if (enter_done) begin
            irq_pend_d = 1'b1;
        end
        if (soft_rst) begin
            irq_en_d   = 1'b0;
            irq_pend_d = 1'b0;
        end
    end

    // Interrupt registers.
    always_ff @(posedge clk or posedge aclr) begin
        if (aclr) begin
            irq_en_q   <= 1'b0;
            irq_pend_q <= 1'b0;
        end else begin
            irq_en_q   <= irq_en_d;
            irq_pend_q <= irq_pend_d;
        end
    end

    assign irq_en_rd   = irq_en_q;
    assign irq_pend_rd = irq_pend_q;
    assign irq         = irq_pend_q & irq_en_q;

    logic unused_wdata;
    assign unused_wdata = ^writedata;
`else
    assign irq_en_rd   = 1'b0;
    assign irq_pend_rd = 1'b0;
    assign irq         = 1'b0;

    logic unused_irq;
    assign unused_irq = ^{writedata, start_ok, enter_done, status_w1c};
`endif

endmodule

// File: tb/tb_full_fn_csr_seq.sv
// Directed self-checking bench for full_fn_csr_seq. Models the accelerator as a
// fixed 3-cycle result pipeline fed by the gated m_valid/m_ready handshake.
module tb_full_fn_csr_seq;

    logic        clk;
    logic        aclr;
    logic        read;
    logic        write;
    logic [2:0]  address;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        s_valid;
    logic        s_ready;
    logic        m_valid;
    logic        m_ready;
    logic        res_valid;
    logic        res_ready;
    logic        irq;

    int passed;
    int total;
    int beat_cnt;
    logic [2:0] pipe;

`ifdef FULL_FN_IRQ_EN
    localparam logic [31:0] IrqBit = 32'h8;
`else
    localparam logic [31:0] IrqBit = 32'h0;
`endif

    full_fn_csr_seq #(.CNT_W(32), .ADDR_W(3)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .read      (read),
        .write     (write),
        .address   (address),
        .writedata (writedata),
        .readdata  (readdata),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .irq       (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Accelerator stand-in: each accepted input returns a result 3 cycles later.
    always @(posedge clk) begin
        pipe <= {pipe[1:0], m_valid & m_ready};
        if (m_valid && m_ready) beat_cnt <= beat_cnt + 1;
    end
    assign res_valid = pipe[2];

    task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
        @(negedge clk);
        write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        write = 1'b0;
    endtask

    task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
        @(negedge clk);
        read = 1'b1; address = a;
        @(negedge clk);
        read = 1'b0;
        d = readdata;
    endtask

    task automatic check_reg(input string name, input logic [2:0] a, input logic [31:0] exp);
        logic [31:0] v;
        bus_read(a, v);
        total++;
        if (v !== exp) $display("FAIL %s: got %h expected %h", name, v, exp);
        else passed++;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        aclr = 1'b1;
        wait_cycles(2);
        total++;
        if ({readdata, m_valid, s_ready, irq} !== 35'h0)
            $display("FAIL reset_outputs: got %h expected 0", {readdata, m_valid, s_ready, irq});
        else passed++;
        aclr = 1'b0;
        wait_cycles(1);
        check_reg("reset_status", 3'd2, 32'h0);
        check_reg("reset_count", 3'd1, 32'h0);
        check_reg("version", 3'd5, 32'h0002_0000);
        check_reg("unmapped6", 3'd6, 32'h0);
    endtask

    task automatic test_basic_job;
        int b0;
        b0 = beat_cnt;
        s_valid = 1'b1; m_ready = 1'b1;
        bus_write(3'd1, 32'd4);
        bus_write(3'd0, 32'h2);
        total++;
        if (m_valid !== 1'b1) $display("FAIL gate_open: got %b expected 1", m_valid);
        else passed++;
        wait_cycles(20);
        total++;
        if (beat_cnt - b0 !== 4) $display("FAIL basic_beats: got %0d expected 4", beat_cnt - b0);
        else passed++;
        total++;
        if (m_valid !== 1'b0) $display("FAIL gate_closed: got %b expected 0", m_valid);
        else passed++;
        check_reg("basic_issued", 3'd4, 32'd4);
        check_reg("basic_progress", 3'd3, 32'd4);
        check_reg("basic_status", 3'd2, 32'h2 | IrqBit);
    endtask

    task automatic test_zero_count;
        int b0;
        b0 = beat_cnt;
        bus_write(3'd1, 32'd0);
        bus_write(3'd0, 32'h2);
        check_reg("zero_status", 3'd2, 32'h2 | IrqBit);
        total++;
        if (beat_cnt - b0 !== 0) $display("FAIL zero_beats: got %0d expected 0", beat_cnt - b0);
        else passed++;
    endtask

    task automatic test_abort_restart;
        s_valid = 1'b0; m_ready = 1'b1;
        bus_write(3'd1, 32'd8);
        bus_write(3'd0, 32'h2);
        s_valid = 1'b1;
        wait_cycles(3);
        s_valid = 1'b0;
        wait_cycles(8);
        bus_write(3'd0, 32'h4);
        s_valid = 1'b1;
        wait_cycles(1);
        total++;
        if ({m_valid, s_ready} !== 2'b00)
            $display("FAIL abort_gate: got %b expected 00", {m_valid, s_ready});
        else passed++;
        s_valid = 1'b0;
        check_reg("abort_status", 3'd2, 32'h4);
        check_reg("abort_issued", 3'd4, 32'd3);
        check_reg("abort_progress", 3'd3, 32'd3);
        // Restart with the stream idle so the cleared counters are observable.
        bus_write(3'd0, 32'h2);
        check_reg("restart_issued", 3'd4, 32'd0);
        check_reg("restart_status", 3'd2, 32'h1);
        bus_write(3'd1, 32'd9);
        check_reg("count_busy_hold", 3'd1, 32'd8);
        s_valid = 1'b1;
        wait_cycles(25);
        s_valid = 1'b0;
        check_reg("restart_done", 3'd2, 32'h2 | IrqBit);
        check_reg("restart_issued_full", 3'd4, 32'd8);
    endtask

    task automatic test_rw_collision;
        @(negedge clk);
        read = 1'b1; write = 1'b1; address = 3'd1; writedata = 32'd5;
        @(negedge clk);
        read = 1'b0; write = 1'b0;
        total++;
        if (readdata !== 32'd8) $display("FAIL rw_readdata: got %h expected 8", readdata);
        else passed++;
        check_reg("rw_write_dropped", 3'd1, 32'd8);
    endtask

    task automatic test_irq;
`ifdef FULL_FN_IRQ_EN
        bus_write(3'd1, 32'd2);
        bus_write(3'd0, 32'hA);
        total++;
        if (irq !== 1'b0) $display("FAIL irq_cleared_by_start: got %b expected 0", irq);
        else passed++;
        check_reg("irq_en_readback", 3'd0, 32'h8);
        s_valid = 1'b1;
        wait_cycles(15);
        s_valid = 1'b0;
        total++;
        if (irq !== 1'b1) $display("FAIL irq_set: got %b expected 1", irq);
        else passed++;
        bus_write(3'd2, 32'h8);
        total++;
        if (irq !== 1'b0) $display("FAIL irq_w1c: got %b expected 0", irq);
        else passed++;
`else
        total++;
        if (irq !== 1'b0) $display("FAIL irq_tied: got %b expected 0", irq);
        else passed++;
        bus_write(3'd0, 32'h8);
        check_reg("irq_en_absent", 3'd0, 32'h0);
`endif
    endtask

    task automatic test_soft_reset;
        bus_write(3'd1, 32'd3);
        bus_write(3'd0, 32'h1);
        check_reg("soft_count", 3'd1, 32'h0);
        check_reg("soft_status", 3'd2, 32'h0);
        check_reg("soft_issued", 3'd4, 32'h0);
    endtask

    task automatic test_aclr_midjob;
        logic [31:0] v;
        s_valid = 1'b1; m_ready = 1'b1;
        bus_write(3'd1, 32'd8);
        bus_write(3'd0, 32'h2);
        bus_read(3'd4, v);
        total++;
        if (v === 32'd0) $display("FAIL midjob_issued: got %h expected nonzero", v);
        else passed++;
        #2 aclr = 1'b1;
        #1;
        total++;
        if ({readdata, m_valid, s_ready} !== 34'h0)
            $display("FAIL aclr_async: got %h expected 0", {readdata, m_valid, s_ready});
        else passed++;
        wait_cycles(2);
        aclr = 1'b0;
        check_reg("aclr_status", 3'd2, 32'h0);
        check_reg("aclr_progress", 3'd3, 32'h0);
        check_reg("aclr_issued", 3'd4, 32'h0);
        s_valid = 1'b0;
    endtask

    initial begin
        passed = 0; total = 0; beat_cnt = 0; pipe = 3'b0;
        read = 1'b0; write = 1'b0; address = 3'd0; writedata = 32'd0;
        s_valid = 1'b0; m_ready = 1'b0; res_ready = 1'b1;
        test_reset;
        test_basic_job;
        test_zero_count;
        test_abort_restart;
        test_rw_collision;
        test_irq;
        test_soft_reset;
        test_aclr_midjob;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
